// File: rtl/sample_pkg.sv
// sample_pkg: shared sample type and I2S timing defaults.
//   sample_t       : packed stereo word {lc, rc}, SAMPLE_W bits per channel
//   I2S_SLOT_WIDTH : default SCLK periods per channel slot
//   I2S_SCLK_DIV   : default clk cycles per SCLK period
package sample_pkg;

    localparam int SAMPLE_W       = 24;
    localparam int I2S_SLOT_WIDTH = 32;
    localparam int I2S_SCLK_DIV   = 4;

    typedef struct packed {
        logic [SAMPLE_W-1:0] lc;
        logic [SAMPLE_W-1:0] rc;
    } sample_t;

    // Position of a bit counter value inside its channel slot.
    function automatic int slot_pos(input int bit_idx, input int slot_width);
        return (bit_idx >= slot_width) ? bit_idx - slot_width : bit_idx;
    endfunction

endpackage

// File: rtl/i2s_tx_clk_gen.sv
// i2s_clk_gen: SCLK / LRCLK timebase for the I2S transmitter.
//   clk, rst_n   : system clock, async active-low reset
//   sclk_o       : registered bit clock, low for first half of div period
//   lrclk_o      : registered word select, changes only on SCLK falling edge
//   fall_o       : high in the clk before an SCLK falling edge (div wrap)
//   load_o       : high in the clk before the frame boundary (load point)
//   bit_nxt_o    : bit counter value that becomes current at the next edge
// Macro I2S_TX_LJ_EN selects left-justified word-select polarity.
module i2s_clk_gen
    import sample_pkg::*;
#(
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int SCLK_DIV   = I2S_SCLK_DIV,
    parameter int BIT_W      = $clog2(2*SLOT_WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             sclk_o,
    output logic             lrclk_o,
    output logic             fall_o,
    output logic             load_o,
    output logic [BIT_W-1:0] bit_nxt_o
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(SCLK_DIV-1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV/2);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2*SLOT_WIDTH-1);
    localparam logic [BIT_W-1:0] SLOT     = BIT_W'(SLOT_WIDTH);

    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic             sclk_q, sclk_d;
    logic             lr_q, lr_d;
    logic             fall;

    always_comb begin
        fall   = (div_q == DIV_MAX);
        div_d  = fall ? '0 : div_q + 1'b1;
        bit_d  = bit_q;
        lr_d   = lr_q;
        // Explicit wrap: 2*SLOT_WIDTH need not be a power of two.
        if (fall) begin
            bit_d = (bit_q == BIT_MAX) ? '0 : bit_q + 1'b1;
`ifdef I2S_TX_LJ_EN
            lr_d  = (bit_d < SLOT);
`else
            lr_d  = (bit_d >= SLOT);
`endif
        end
        // sclk is registered from the next divider value so its falling
        // edge lines up with the data/word-select update.
        sclk_d = (div_d >= DIV_HALF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            lr_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sclk_q <= sclk_d;
            lr_q   <= lr_d;
        end
    end

    assign sclk_o    = sclk_q;
    assign lrclk_o   = lr_q;
    assign fall_o    = fall;
    assign load_o    = fall && (bit_q == BIT_MAX);
    assign bit_nxt_o = bit_d;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo sample serializer, Philips I2S (or left-justified when
// macro I2S_TX_LJ_EN is defined).
//   clk, rst_n : system clock, async active-low reset
//   data_i     : stereo sample {lc, rc}, two's complement
//   vld_i      : single-cycle valid for data_i, no backpressure
//   sclk_o     : bit clock (SCLK_DIV clk per period)
//   lrclk_o    : word select, 0 = left (I2S)
//   sdata_o    : serial data, MSB first
//   frame_o    : pulse when a frame is loaded
//   ovf_o      : pulse when a pending sample is overwritten
//   udf_o      : pulse when a frame loads silence (nothing pending)
module i2s_tx
    import sample_pkg::*;
#(
    parameter int DATA_WIDTH = SAMPLE_W,
    parameter int SLOT_WIDTH = I2S_SLOT_WIDTH,
    parameter int SCLK_DIV   = I2S_SCLK_DIV
) (
    input  logic    clk,
    input  logic    rst_n,
    input  sample_t data_i,
    input  logic    vld_i,
    output logic    sclk_o,
    output logic    lrclk_o,
    output logic    sdata_o,
    output logic    frame_o,
    output logic    ovf_o,
    output logic    udf_o
);

    localparam int BIT_W = $clog2(2*SLOT_WIDTH);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    logic             fall, load;
    logic [BIT_W-1:0] bit_nxt;

    sample_t pend_q, pend_d;
    logic    pend_vld_q, pend_vld_d;
    sample_t frame_q, frame_d;
    logic    sdata_q, sdata_d;
    logic    frm_q, frm_d;
    logic    ovf_q, ovf_d;
    logic    udf_q, udf_d;

    logic [SAMPLE_W-1:0] ch;
    int                  b, p;

    i2s_clk_gen #(
        .SLOT_WIDTH (SLOT_WIDTH),
        .SCLK_DIV   (SCLK_DIV),
        .BIT_W      (BIT_W)
    ) u_clk_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk_o    (sclk_o),
        .lrclk_o   (lrclk_o),
        .fall_o    (fall),
        .load_o    (load),
        .bit_nxt_o (bit_nxt)
    );

    // Pending register and frame load.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        frame_d    = frame_q;
        frm_d      = 1'b0;
        ovf_d      = 1'b0;
        udf_d      = 1'b0;
        if (load) begin
            frm_d = 1'b1;
            if (pend_vld_q) begin
                // Old pending goes out; a coincident sample waits its turn.
                frame_d    = pend_q;
                pend_vld_d = vld_i;
                if (vld_i) pend_d = data_i;
            end else if (vld_i) begin
                frame_d    = data_i;
                pend_vld_d = 1'b0;
            end else begin
                frame_d    = '0;
                udf_d      = 1'b1;
            end
        end else if (vld_i) begin
            pend_d     = data_i;
            pend_vld_d = 1'b1;
            ovf_d      = pend_vld_q;
        end
    end

    // Serial data for the bit that becomes current at the next falling
    // edge. frame_d is used so the first bit of a frame sees new data.
    always_comb begin
        sdata_d = sdata_q;
        b       = int'(bit_nxt);
        p       = slot_pos(b, SLOT_WIDTH);
        ch      = (b >= SLOT_WIDTH) ? frame_d.rc : frame_d.lc;
        if (fall) begin
            sdata_d = 1'b0;
`ifdef I2S_TX_LJ_EN
            if (p < DATA_WIDTH)
                sdata_d = ch[IDX_W'(DATA_WIDTH-1-p)];
`else
            if (p >= 1 && p <= DATA_WIDTH)
                sdata_d = ch[IDX_W'(DATA_WIDTH-p)];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            frame_q    <= '0;
            sdata_q    <= 1'b0;
            frm_q      <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            frame_q    <= frame_d;
            sdata_q    <= sdata_d;
            frm_q      <= frm_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    assign sdata_o = sdata_q;
    assign frame_o = frm_q;
    assign ovf_o   = ovf_q;
    assign udf_o   = udf_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized/directed bench for i2s_tx with a frame-level scoreboard.
// Cycle t = state after t clk rising edges since reset release.
module tb_i2s_tx;
    import sample_pkg::*;

    localparam int DW   = 24;
    localparam int SLOT = 32;
    localparam int DIV  = 4;
    localparam int FRM  = 2*SLOT*DIV;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    sample_t data_i = '0;
    logic    vld_i = 1'b0;
    logic    sclk_o, lrclk_o, sdata_o, frame_o, ovf_o, udf_o;

    always #5 clk = ~clk;

    i2s_tx dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .vld_i   (vld_i),
        .sclk_o  (sclk_o),
        .lrclk_o (lrclk_o),
        .sdata_o (sdata_o),
        .frame_o (frame_o),
        .ovf_o   (ovf_o),
        .udf_o   (udf_o)
    );

    typedef struct {
        sample_t d;
        bit      udf;
    } frm_t;

    int      checks = 0;
    int      failures = 0;
    int      t = 0;
    bit      mon_en = 0;
    frm_t    exp_q[$];
    int      ovf_q[$];
    int      plan_t[$];
    sample_t plan_d[$];
    bit      m_pv;
    sample_t m_pend;

    // monitor capture state
    bit      cap_act = 0;
    int      cap_s;
    frm_t    cap_exp;
    bit      bits[2*SLOT];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    // Transaction-level reference: what each frame boundary should carry.
    task automatic model_step(input int tc, input bit v, input sample_t nd);
        bit   ld;
        frm_t f;
        ld = (tc >= FRM-1) && ((tc - (FRM-1)) % FRM == 0);
        if (ld) begin
            if (m_pv) begin
                f.d = m_pend; f.udf = 0;
                m_pv = v;
                if (v) m_pend = nd;
            end else if (v) begin
                f.d = nd; f.udf = 0;
            end else begin
                f.d = '0; f.udf = 1;
            end
            exp_q.push_back(f);
        end else if (v) begin
            if (m_pv) ovf_q.push_back(tc + 1);
            m_pend = nd;
            m_pv   = 1;
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        rst_n  = 1'b0;
        vld_i  = 1'b0;
        data_i = '0;
        #1;
        chk("rst_outs", {58'd0, sclk_o, lrclk_o, sdata_o, frame_o, ovf_o, udf_o}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        m_pv = 0;
        m_pend = '0;
        exp_q.delete();
        ovf_q.delete();
        plan_t.delete();
        plan_d.delete();
        cap_act = 0;
        #1 mon_en = 1;
    endtask

    task automatic plan(input int tc, input sample_t d);
        plan_t.push_back(tc);
        plan_d.push_back(d);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            bit      v;
            sample_t nd;
            v  = (plan_t.size() > 0) && (plan_t[0] == t);
            nd = '0;
            if (v) begin
                nd = plan_d.pop_front();
                void'(plan_t.pop_front());
            end
            vld_i  = v;
            data_i = nd;
            model_step(t, v, nd);
            @(posedge clk);
            #1;
            t++;
        end
        vld_i  = 1'b0;
        data_i = '0;
    endtask

    task automatic end_phase(input string name);
        @(negedge clk);
        #1;
        chk({name, "_frames_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_ovf_left"}, 64'(ovf_q.size()), 64'd0);
    endtask

    // Monitor: per-cycle timebase checks plus frame reassembly.
    always @(negedge clk) begin
        if (mon_en) begin
            int      b, d, e;
            bit      exp_lr, exp_fr;
            sample_t got;
            bit      pad;
            b = (t / DIV) % (2*SLOT);
            chk("sclk", 64'(sclk_o), 64'((t % DIV) >= DIV/2));
`ifdef I2S_TX_LJ_EN
            exp_lr = (t < DIV) ? 1'b0 : (b < SLOT);
`else
            exp_lr = (b >= SLOT);
`endif
            chk("lrclk", 64'(lrclk_o), 64'(exp_lr));
            exp_fr = (t >= FRM) && ((t - FRM) % FRM == 0);
            chk("frame_o", 64'(frame_o), 64'(exp_fr));
            if (ovf_o && udf_o) chk("ovf_udf_excl", 64'd1, 64'd0);
            if (frame_o) begin
                if (exp_q.size() == 0) begin
                    chk("frame_pop", 64'd1, 64'd0);
                    cap_act = 0;
                end else begin
                    cap_exp = exp_q.pop_front();
                    chk("udf_o", 64'(udf_o), 64'(cap_exp.udf));
                    cap_act = 1;
                    cap_s   = t;
                end
            end else if (udf_o) begin
                chk("udf_stray", 64'd1, 64'd0);
            end
            if (ovf_q.size() > 0 && ovf_q[0] < t) begin
                chk("ovf_missing", 64'(t), 64'(ovf_q.pop_front()));
            end
            if (ovf_o) begin
                e = (ovf_q.size() > 0) ? ovf_q.pop_front() : -1;
                chk("ovf_cycle", 64'(t), 64'(e));
            end
            if (cap_act) begin
                d = t - cap_s;
                if (d % DIV == DIV/2) begin
                    bits[d / DIV] = sdata_o;
                    if (d / DIV == 2*SLOT-1) begin
                        got = '0;
                        pad = 0;
                        for (int i = 0; i < SLOT; i++) begin
`ifdef I2S_TX_LJ_EN
                            if (i < DW) begin
                                got.lc[DW-1-i] = bits[i];
                                got.rc[DW-1-i] = bits[SLOT+i];
                            end else pad = pad | bits[i] | bits[SLOT+i];
`else
                            if (i >= 1 && i <= DW) begin
                                got.lc[DW-i] = bits[i];
                                got.rc[DW-i] = bits[SLOT+i];
                            end else pad = pad | bits[i] | bits[SLOT+i];
`endif
                        end
                        chk("frame_data", 64'(got), 64'(cap_exp.d));
                        chk("pad_bits", 64'(pad), 64'd0);
                        cap_act = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0d actual=running expected=finished", t);
        $fatal(1, "timeout");
    end

    initial begin
        sample_t x, y;
        // A: idle, udf every frame
        do_reset();
        run(700);
        end_phase("idle");

        // B: single sample, known pattern
        do_reset();
        plan(10, '{lc: 24'hA5A5A5, rc: 24'h800001});
        run(700);
        end_phase("single");

        // C: overwrite before load
        do_reset();
        x = '{lc: 24'h123456, rc: 24'h654321};
        y = '{lc: 24'h800000, rc: 24'h7FFFFF};
        plan(10, x);
        plan(20, y);
        run(700);
        end_phase("ovf");

        // D: sample exactly at load point, nothing pending
        do_reset();
        plan(FRM-1, '{lc: 24'hFFFFFF, rc: 24'h000001});
        run(700);
        end_phase("ld_direct");

        // E: sample at load point with one pending, then overwrite
        do_reset();
        plan(300, '{lc: 24'h111111, rc: 24'h222222});
        plan(2*FRM-1, '{lc: 24'h333333, rc: 24'h444444});
        plan(600, '{lc: 24'h555555, rc: 24'h666666});
        run(1100);
        end_phase("ld_pend");

        // F: reset in the middle of the right slot, then restart
        do_reset();
        plan(10, '{lc: 24'hFFFFFF, rc: 24'hFFFFFF});
        run(FRM + 40*DIV + 1);
        do_reset();
        run(700);
        end_phase("midreset");

        // G: random traffic, with forced load-point arrivals
        do_reset();
        for (int tc = 1; tc < 4000; tc++) begin
            if ($urandom_range(0, 149) == 0 || tc == 4*FRM-1 || tc == 8*FRM-1)
                plan(tc, sample_t'({$urandom(), $urandom()}));
        end
        run(4000);
        end_phase("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
